versatile_fifo_wr_arb: RTL and testbench
========================================

# versatile_fifo_wr_arb

Write-side controller for the versatile FIFO. Shares a single FIFO write port among `NR` requesters with round-robin arbitration and bounded bursts. It generates the dual-port RAM write strobe, address and data, and maintains the Gray-coded write pointer `wptr` consumed by the asynchronous full/empty comparator. It runs entirely in the write clock domain and obeys the comparator's synchronised `fifo_full`.

## Interface
Parameters:
- `ADDR_WIDTH`, 6: FIFO address width; depth is 2^ADDR_WIDTH. Must match the comparator.
- `DATA_WIDTH`, 8: word width.
- `NR`, 4: number of requesters, 2..8.
- `BURST`, 4: maximum words accepted per grant, 1..16.

Ports:
- `wclk`, in, 1: write clock.
- `rst`, in, 1: reset. **One clock; reset is synchronous and active-high.**
- `req`, in, NR: per-requester write request; a word is pending while high.
- `dat`, in, NR*DATA_WIDTH: per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ack`, out, NR: combinational. The word from requester i is consumed at the wclk edge where `req[i] && ack[i]`.
- `fifo_full`, in, 1: full flag from the comparator, already in the wclk domain.
- `mem_we`, out, 1: RAM write enable. Combinational; equals the OR of `req & ack`.
- `mem_adr`, out, ADDR_WIDTH: binary RAM write address.
- `mem_dat`, out, DATA_WIDTH: `dat` slice of the granted requester.
- `wptr`, out, ADDR_WIDTH: registered Gray write pointer to the comparator.
- `gnt_id`, out, clog2(NR): index of the current or last granted requester.
- `busy`, out, 1: high in state BURST.

## Operation
- States:
  - IDLE: no grant; all `ack` are 0.
  - BURST: requester `gnt_id` holds the port.
- IDLE transition: if any `req` bit is set and `fifo_full`=0, pick the first set `req` bit searching from `gnt_id+1` upward, modulo NR. Load `gnt_id` with it, clear `bcnt`, and go to BURST.
- IDLE with no request, or with `fifo_full`=1: stay in IDLE.
- In BURST, `ack[gnt_id] = req[gnt_id] && !fifo_full`; all other `ack` bits are 0.
- On an accepted word at a wclk edge, all of the following happen at that edge:
  - The RAM writes `mem_dat` at `mem_adr`.
  - The binary counter `bin` increments modulo 2^ADDR_WIDTH.
  - `wptr` becomes bin2gray(`bin`+1).
  - `bcnt` increments.
- BURST exits to IDLE when either:
  - a word is accepted with `bcnt`=BURST-1, or
  - `req[gnt_id]`=0 at an edge; that cycle accepts nothing.
- `fifo_full`=1 in BURST: the grant is held, no ack is given, and `bcnt` is unchanged.
- `mem_adr` = `bin`; `wptr` = `bin ^ (bin >> 1)`, held in a register. Both wrap from 2^ADDR_WIDTH-1 to 0 with no extra bit; the comparator's direction logic resolves full versus empty.
- Reset values: state IDLE, `bin`=0, `wptr`=0, `gnt_id`=NR-1 (so requester 0 wins first), `bcnt`=0, `ack`=0, `mem_we`=0, `busy`=0.
- Reset mid-burst abandons the burst and zeroes the pointer. `rst` must be asserted together with the read side.

## Timing
- Arbitration costs one cycle: `req` is sampled in IDLE at edge e, and the first `ack` is possible in the cycle after e.
- Sustained throughput under contention: BURST words per BURST+1 cycles.
- Single requester with BURST words pending: `ack` is high for BURST consecutive cycles, then the block spends one IDLE cycle.
- `wptr` changes only on accepting edges, by exactly one Gray step.
- `fifo_full` is set asynchronously by the comparator before the next edge after the filling write, so `ack` drops in that same cycle and no overrun occurs.
- `fifo_full` deasserts with 2-wclk latency; writes resume in the first cycle it reads 0.

## Structure
- Package `versatile_fifo_pkg`: state encoding (IDLE, BURST), `bin2gray` function, and quadrant constants Q1..Q4 shared with the comparator.
- Sub-module `versatile_fifo_gray_cnt`: binary plus registered Gray counter with enable. Parameter ADDR_WIDTH; outputs `bin` and `gray`.
- The arbiter FSM, round-robin search and output mux stay in the top module.

## Test plan
- Reset, then `req`=4'b0001 with data 0x10..0x13, BURST=4 → 4 acks on consecutive cycles; `mem_adr` 0,1,2,3; `wptr` sequence 1,3,2,6; then IDLE.
- `req`=4'b1111 held → `gnt_id` order 0,1,2,3,0; each grant yields 4 words then 1 idle cycle; 16 words in 20 cycles.
- Tie `fifo_full` to comparator, with the read side stalled and ADDR_WIDTH=3 → exactly 8 words accepted; `ack` is 0 in the cycle `fifo_full` rises; `wptr` returns to 0.
- With `fifo_full` high in BURST for 5 cycles, then low → the grant is held, `bcnt` is unchanged, and acks resume without re-arbitration.
- `req[gnt_id]` drops after 2 words → IDLE at the next edge, and the next grant goes to the next set requester.
- Assert `rst` during the third word of a burst → at the next edge: state IDLE, `wptr`=0, `ack`=0, `gnt_id`=NR-1.

Source files
------------

// File: rtl/versatile_fifo_pkg.sv
// Shared definitions for the versatile FIFO: write-side state encoding,
// Gray conversion and the quadrant codes used by the full/empty comparator.
package versatile_fifo_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } wr_state_e;

    // Top two Gray pointer bits name the quadrant; the comparator watches
    // quadrant transitions to tell a full FIFO from an empty one.
    localparam logic [1:0] Q1 = 2'b00;
    localparam logic [1:0] Q2 = 2'b01;
    localparam logic [1:0] Q3 = 2'b11;
    localparam logic [1:0] Q4 = 2'b10;

    // Callers cast the result down to their own pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/versatile_fifo_gray_cnt.sv
// Binary counter with a registered Gray copy; both advance together on en.
module versatile_fifo_gray_cnt
    import versatile_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] bin,
    output logic [ADDR_WIDTH-1:0] gray
);

    logic [ADDR_WIDTH-1:0] bin_q;
    logic [ADDR_WIDTH-1:0] gray_q;
    logic [ADDR_WIDTH-1:0] bin_next;

    // Wraps to zero with no extra bit; the comparator resolves direction.
    assign bin_next = bin_q + ADDR_WIDTH'(1);

    // Advance both copies together so gray always equals bin2gray(bin).
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else if (en) begin
            bin_q  <= bin_next;
            gray_q <= ADDR_WIDTH'(bin2gray(32'(bin_next)));
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;

endmodule

// File: rtl/versatile_fifo_wr_arb.sv
// Write-side controller: round-robin arbitration of NR requesters onto the
// single FIFO write port, bounded bursts, RAM write strobe and Gray pointer.
module versatile_fifo_wr_arb
    import versatile_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NR         = 4,
    parameter int unsigned BURST      = 4,
    localparam int unsigned GW        = $clog2(NR)
) (
    input  logic                     wclk,
    input  logic                     rst,
    input  logic [NR-1:0]            req,
    input  logic [NR*DATA_WIDTH-1:0] dat,
    output logic [NR-1:0]            ack,
    input  logic                     fifo_full,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_adr,
    output logic [DATA_WIDTH-1:0]    mem_dat,
    output logic [ADDR_WIDTH-1:0]    wptr,
    output logic [GW-1:0]            gnt_id,
    output logic                     busy
);

    localparam int unsigned BCW = $clog2(BURST + 1);
    localparam logic [BCW-1:0] BcntLast = BCW'(BURST - 1);

    wr_state_e      state_q;
    logic [GW-1:0]  gnt_q;
    logic [BCW-1:0] bcnt_q;
    logic [GW-1:0]  next_gnt;
    logic           accept;

    // Round-robin pick: first set req searching upward from gnt_q+1 mod NR.
    // Walking from the farthest candidate inward lets the nearest one win.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        next_gnt = gnt_q;
        for (int unsigned k = NR; k >= 1; k--) begin
            idx = (32'(gnt_q) + k) % NR;
            if (req[GW'(idx)]) begin
                next_gnt = GW'(idx);
            end
        end
    end

    // Only the granted requester may be acked, and never while full.
    always_comb begin
        ack = '0;
        if (state_q == StBurst && !fifo_full) begin
            ack[gnt_q] = req[gnt_q];
        end
    end

    assign accept = |(req & ack);

    // Data mux for the granted requester.
    always_comb begin
        mem_dat = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (gnt_q == GW'(i)) begin
                mem_dat = dat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Arbiter FSM: one arbitration cycle in idle, then up to BURST words.
    always_ff @(posedge wclk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= GW'(NR - 1);
            bcnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req && !fifo_full) begin
                        gnt_q   <= next_gnt;
                        bcnt_q  <= '0;
                        state_q <= StBurst;
                    end
                end
                StBurst: begin
                    if (!req[gnt_q]) begin
                        state_q <= StIdle;
                    end else if (accept) begin
                        bcnt_q <= bcnt_q + BCW'(1);
                        if (bcnt_q == BcntLast) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    versatile_fifo_gray_cnt #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_gray_cnt (
        .clk (wclk),
        .rst (rst),
        .en  (accept),
        .bin (mem_adr),
        .gray(wptr)
    );

    assign mem_we = accept;
    assign gnt_id = gnt_q;
    assign busy   = (state_q == StBurst);

endmodule

// File: tb/tb_versatile_fifo_wr_arb.sv
// Scoreboard bench for versatile_fifo_wr_arb (ADDR_WIDTH=3, NR=4, BURST=4).
module tb_versatile_fifo_wr_arb;

    logic        wclk = 1'b0;
    logic        rst  = 1'b1;
    logic [3:0]  req  = '0;
    logic [31:0] dat  = '0;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        mem_we;
    logic [2:0]  mem_adr;
    logic [7:0]  mem_dat;
    logic [2:0]  wptr;
    logic [1:0]  gnt_id;
    logic        busy;

    logic        full_mode = 1'b0;
    int          occ;
    int          tests = 0;
    int          fails = 0;
    logic [2:0]  exp_adr = '0;

    typedef struct {
        int         id;
        logic [2:0] adr;
        logic [7:0] d;
        logic [2:0] wp;
    } exp_t;
    exp_t sb[$];

    // Comparator model with the read side stalled: full once 8 words are in.
    assign fifo_full = full_mode && (occ >= 8);

    versatile_fifo_wr_arb #(
        .ADDR_WIDTH(3),
        .DATA_WIDTH(8),
        .NR        (4),
        .BURST     (4)
    ) dut (
        .wclk     (wclk),
        .rst      (rst),
        .req      (req),
        .dat      (dat),
        .ack      (ack),
        .fifo_full(fifo_full),
        .mem_we   (mem_we),
        .mem_adr  (mem_adr),
        .mem_dat  (mem_dat),
        .wptr     (wptr),
        .gnt_id   (gnt_id),
        .busy     (busy)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) begin
        if (rst) occ <= 0;
        else if (mem_we) occ <= occ + 1;
    end

    function automatic logic [2:0] gray3(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic expect_word(input int id, input logic [7:0] d);
        exp_t e;
        e.id  = id;
        e.adr = exp_adr;
        e.d   = d;
        e.wp  = gray3(exp_adr);
        sb.push_back(e);
        exp_adr = exp_adr + 3'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_adr = '0;
    endtask

    task automatic wait_ack(input int id);
        int n;
        n = 0;
        while (ack[id] !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        tests++;
        if (ack[id] !== 1'b1) begin
            fails++;
            $display("FAIL ack_wait[%0d]: ack=%b, required ack[%0d]=1 within 12 cycles",
                     id, ack, id);
        end
    endtask

    // Present n consecutive words from requester id, each consumed on its ack.
    task automatic feed(input int id, input int n, input logic [7:0] first);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            d = 8'(32'(first) + k);
            dat[id*8 +: 8] = d;
            expect_word(id, d);
            #1;
            wait_ack(id);
            step();
        end
    endtask

    // Monitor: every write presented must match the head of the scoreboard.
    always @(negedge wclk) begin
        exp_t e;
        if (!rst && mem_we) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: adr=%0d dat=0x%0h, required no write",
                         mem_adr, mem_dat);
            end else begin
                e = sb.pop_front();
                check("mon_adr", 32'(mem_adr), 32'(e.adr));
                check("mon_dat", 32'(mem_dat), 32'(e.d));
                check("mon_wptr", 32'(wptr), 32'(e.wp));
                check("mon_gnt", 32'(gnt_id), 32'(e.id));
                check("mon_ack", 32'(ack), 32'(1) << e.id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;

        // Reset state and single-requester burst.
        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_wptr", 32'(wptr), 0);
        check("rst_adr", 32'(mem_adr), 0);
        check("rst_gnt", 32'(gnt_id), 3);
        check("rst_ack", 32'(ack), 0);
        check("rst_we", 32'(mem_we), 0);

        dat[7:0] = 8'h10;
        req = 4'b0001;
        for (int k = 0; k < 4; k++) expect_word(0, 8'(8'h10 + k));
        #1;
        check("t1_arb_ack", 32'(ack), 0);
        step();
        for (int k = 0; k < 4; k++) begin
            check("t1_ack", 32'(ack), 32'h1);
            step();
            dat[7:0] = 8'(8'h11 + k);
        end
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_idle_ack", 32'(ack), 0);
        check("t1_wptr", 32'(wptr), 32'h6);
        check("t1_adr", 32'(mem_adr), 32'h4);
        req = 4'b0000;
        step();

        // Full contention: grants 0,1,2,3 then 0; 16 words in 20 cycles.
        do_reset();
        dat = 32'hA3A2A1A0;
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++) expect_word(g, 8'(8'hA0 + g));
        req = 4'b1111;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge wclk);
            if (mem_we) cnt++;
        end
        step();
        check("t2_words", 32'(cnt), 16);
        check("t2_idle_busy", 32'(busy), 0);
        step();
        check("t2_wrap_gnt", 32'(gnt_id), 0);
        check("t2_wrap_busy", 32'(busy), 1);
        req = 4'b0000;
        step();
        check("t2_end_busy", 32'(busy), 0);

        // Fill to full with the read side stalled, hold full, then release.
        do_reset();
        full_mode = 1'b1;
        req = 4'b0001;
        step();
        feed(0, 3, 8'h30);
        req = 4'b0000;
        step();
        step();
        req = 4'b0001;
        step();
        feed(0, 5, 8'h33);
        check("t3_full_busy", 32'(busy), 1);
        check("t3_full_ack", 32'(ack), 0);
        check("t3_full_we", 32'(mem_we), 0);
        check("t3_full_wptr", 32'(wptr), 0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("t3_hold_ack", 32'(ack), 0);
            check("t3_hold_gnt", 32'(gnt_id), 0);
        end
        check("t3_occ", 32'(occ), 8);
        full_mode = 1'b0;
        dat[7:0] = 8'h38;
        #1;
        check("t4_resume_ack", 32'(ack), 32'h1);
        feed(0, 3, 8'h38);
        check("t4_burst_end", 32'(busy), 0);
        req = 4'b0000;
        step();

        // Requester drops after 2 words; next set requester gets the port.
        do_reset();
        dat = 32'h00C00000;
        req = 4'b0101;
        step();
        feed(0, 2, 8'h40);
        req = 4'b0100;
        #1;
        check("t5_drop_ack", 32'(ack), 0);
        step();
        check("t5_drop_busy", 32'(busy), 0);
        step();
        check("t5_next_gnt", 32'(gnt_id), 2);
        check("t5_next_busy", 32'(busy), 1);
        feed(2, 1, 8'hC0);
        req = 4'b0000;
        step();
        check("t5_end_busy", 32'(busy), 0);

        // Reset during the third word of a burst.
        req = 4'b0001;
        step();
        check("t6_gnt", 32'(gnt_id), 0);
        feed(0, 2, 8'h50);
        dat[7:0] = 8'h52;
        #1;
        check("t6_third_ack", 32'(ack), 32'h1);
        rst = 1'b1;
        step();
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_wptr", 32'(wptr), 0);
        check("t6_rst_ack", 32'(ack), 0);
        check("t6_rst_gnt", 32'(gnt_id), 3);
        check("t6_rst_adr", 32'(mem_adr), 0);
        rst = 1'b0;
        req = 4'b0000;
        step();
        step();

        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
